// File: rtl/adc_pkg.sv
// Shared definitions for the parallel ADC capture sequencer.
package adc_pkg;
  localparam int ADC_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_ARMED,
    ST_CAPTURE,
    ST_FLUSH
  } state_t;
endpackage

// File: rtl/adc_clk_gen.sv
// Converter clock divider: adc_clk = clk_25 / (2*CLK_DIV) while enabled, parked low otherwise.
// strobe marks the clk_25 cycle whose closing edge drives adc_clk from 1 to 0.
module adc_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_25,
  input  logic rst,
  input  logic en,
  output logic adc_clk,
  output logic strobe
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;

  assign div_tc = (div_cnt == DIV_TC);
  assign strobe = en && div_tc && adc_clk;

  always_ff @(posedge clk_25) begin
    if (rst || !en) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      adc_clk <= ~adc_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// Frame sequencer for the 8-bit parallel ADC: warm-up, optional trigger, capture, valid/ready stream.
//   state      | meaning
//   ST_IDLE    | converter off, waiting for start
//   ST_WARMUP  | enADC high, discarding ADC_LAT pipeline samples
//   ST_ARMED   | converter running, waiting for trig rising edge
//   ST_CAPTURE | one sample per strobe until frame_len strobes seen
//   ST_FLUSH   | converter off, waiting for last sample to be accepted
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int ADC_LAT = 6,
  parameter int LEN_W   = 16
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              trig_en,
  input  logic              trig,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [ADC_DW-1:0] addata,
  output logic              adc_clk,
  output logic              enADC,
  output logic [ADC_DW-1:0] smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              smp_last,
  output logic              busy,
  output logic              done,
  output logic              overrun
);
  localparam int LAT_W = (ADC_LAT > 1) ? $clog2(ADC_LAT) : 1;

  state_t           state, state_next;
  logic [LAT_W-1:0] warm_cnt;
  logic [LEN_W-1:0] smp_cnt;
  logic             trig_d;
  logic             strobe;
  logic             clk_en;
  logic             start_ok;
  logic             accept;
  logic             cap_strobe;
  logic             last_strobe;
  logic             warm_tc;
  logic             trig_rise;
  logic             done_next;

  assign enADC       = (state == ST_WARMUP) || (state == ST_ARMED) || (state == ST_CAPTURE);
  assign busy        = (state != ST_IDLE);
  // Abort must park adc_clk low on the very next edge, so it gates the divider directly.
  assign clk_en      = enADC && !abort;
  assign start_ok    = start && (state == ST_IDLE) && !done && !abort && (frame_len != '0);
  assign accept      = smp_valid && smp_ready;
  assign cap_strobe  = (state == ST_CAPTURE) && strobe;
  assign last_strobe = cap_strobe && (smp_cnt == LEN_W'(1));
  assign warm_tc     = (warm_cnt == '0);
  assign trig_rise   = trig && !trig_d;

  adc_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk_25 (clk_25),
    .rst    (rst),
    .en     (clk_en),
    .adc_clk(adc_clk),
    .strobe (strobe)
  );

  always_ff @(posedge clk_25) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE:    if (start_ok) state_next = ST_WARMUP;
      ST_WARMUP:  if (strobe && warm_tc) state_next = trig_en ? ST_ARMED : ST_CAPTURE;
      ST_ARMED:   if (trig_rise) state_next = ST_CAPTURE;
      ST_CAPTURE: if (last_strobe) state_next = ST_FLUSH;
      ST_FLUSH: begin
        if (accept) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default:    state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      warm_cnt <= '0;
      smp_cnt  <= '0;
      trig_d   <= 1'b0;
    end else begin
      trig_d <= trig;
      if (start_ok) begin
        warm_cnt <= LAT_W'(ADC_LAT - 1);
        smp_cnt  <= frame_len;
      end else begin
        if ((state == ST_WARMUP) && strobe && !warm_tc) warm_cnt <= warm_cnt - LAT_W'(1);
        if (cap_strobe) smp_cnt <= smp_cnt - LEN_W'(1);
      end
    end
  end

  // A strobe against a stalled output drops the new sample but still counts it,
  // so frame timing never depends on the downstream consumer.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      smp_data  <= '0;
      smp_valid <= 1'b0;
      smp_last  <= 1'b0;
      overrun   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_next;
      if (abort) begin
        smp_valid <= 1'b0;
        smp_last  <= 1'b0;
      end else if (cap_strobe) begin
        if (smp_valid && !smp_ready) begin
          overrun <= 1'b1;
          if (last_strobe) smp_last <= 1'b1;
        end else begin
          smp_data  <= addata;
          smp_valid <= 1'b1;
          smp_last  <= last_strobe;
        end
      end else if (accept) begin
        smp_valid <= 1'b0;
        smp_last  <= 1'b0;
      end
      if (start_ok) overrun <= 1'b0;
    end
  end
endmodule
